// File: rtl/lane_pkg.sv
// Shared lane definitions.
// Purpose : widths of the lane VRF datapath, the write-request beat that
//           LaneStage3 issues, and the byte-merge helper used wherever a
//           masked write meets an existing word.
// Ports   : none (package).
package lane_pkg;

   localparam int VD_WIDTH         = 5;
   localparam int OFFSET_WIDTH     = 8;
   localparam int DATA_WIDTH       = 32;
   localparam int INST_INDEX_WIDTH = 3;

   localparam int MASK_WIDTH = DATA_WIDTH / 8;
   localparam int ADDR_WIDTH = VD_WIDTH + OFFSET_WIDTH;
   localparam int INST_COUNT = 1 << INST_INDEX_WIDTH;

   typedef struct packed {
      logic [VD_WIDTH-1:0]         vd;
      logic [OFFSET_WIDTH-1:0]     offset;
      logic [MASK_WIDTH-1:0]       mask;
      logic [DATA_WIDTH-1:0]       data;
      logic                        last;
      logic [INST_INDEX_WIDTH-1:0] instructionIndex;
   } vrf_write_req_t;

   // Bytes selected by mask come from new_word, the rest from old_word.
   function automatic logic [DATA_WIDTH-1:0] byte_merge(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] new_word,
      input logic [MASK_WIDTH-1:0] mask
   );
      logic [DATA_WIDTH-1:0] merged;
      merged = old_word;
      for (int b = 0; b < MASK_WIDTH; b++) begin
         if (mask[b]) begin
            merged[b*8 +: 8] = new_word[b*8 +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/vrf_bank_masked.sv
// Single-port VRF bank with byte enables and registered read.
// Purpose : storage for one lane's vector registers; kept as its own module
//           so an SRAM macro with the same port shape can replace it.
// Ports   : clk   - clock
//           en    - port access this cycle
//           we    - 1 = masked write, 0 = read
//           addr  - word address
//           wmask - byte enables for a write
//           wdata - write data
//           rdata - read data, valid the cycle after a read access
module vrf_bank_masked #(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    en,
   input  logic                    we,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH/8-1:0] wmask,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   rdata
);

   localparam int MASK_WIDTH = DATA_WIDTH / 8;
   localparam int DEPTH      = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   // Contents and read register are deliberately not reset.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
               if (wmask[b]) begin
                  mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
               end
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/vrf_write_sink.sv
// VRF write sink for one lane.
// Purpose : accepts write beats from LaneStage3 into a one-entry pending
//           register and commits them into the single-ported bank whenever
//           the operand-read stage leaves the port idle. Reads always win the
//           port; a read that hits the pending address sees the pending bytes
//           merged over the stored word. Commits are reported one cycle after
//           they happen so the sequencer can retire writes.
// Ports   : clock, reset                  - clock, synchronous active-high reset
//           vrfWriteRequest_*              - write beat handshake and payload
//           readRequest_*                  - read request (always accepted)
//           readResult_*                   - read data, one cycle after request
//           writeCommit_*                  - per-commit pulse with instruction index
//           instructionWriteDone           - one-hot pulse for a committed last beat
module vrf_write_sink
   import lane_pkg::*;
(
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        vrfWriteRequest_valid,
   output logic                        vrfWriteRequest_ready,
   input  logic [VD_WIDTH-1:0]         vrfWriteRequest_bits_vd,
   input  logic [OFFSET_WIDTH-1:0]     vrfWriteRequest_bits_offset,
   input  logic [MASK_WIDTH-1:0]       vrfWriteRequest_bits_mask,
   input  logic [DATA_WIDTH-1:0]       vrfWriteRequest_bits_data,
   input  logic                        vrfWriteRequest_bits_last,
   input  logic [INST_INDEX_WIDTH-1:0] vrfWriteRequest_bits_instructionIndex,
   input  logic                        readRequest_valid,
   input  logic [VD_WIDTH-1:0]         readRequest_bits_vs,
   input  logic [OFFSET_WIDTH-1:0]     readRequest_bits_offset,
   output logic                        readResult_valid,
   output logic [DATA_WIDTH-1:0]       readResult_bits,
   output logic                        writeCommit_valid,
   output logic [INST_INDEX_WIDTH-1:0] writeCommit_bits_instructionIndex,
   output logic [INST_COUNT-1:0]       instructionWriteDone
);

   vrf_write_req_t        pend_reg;
   logic                  pend_valid_reg;
   logic                  fwd_hit_reg;
   logic [MASK_WIDTH-1:0] fwd_mask_reg;
   logic [DATA_WIDTH-1:0] fwd_data_reg;

   logic                  commit;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] pend_addr;
   logic [ADDR_WIDTH-1:0] read_addr;
   logic [ADDR_WIDTH-1:0] bank_addr;
   logic [DATA_WIDTH-1:0] bank_rdata;
   logic                  fwd_hit_next;
   logic [INST_COUNT-1:0] done_next;

   assign pend_addr = {pend_reg.vd, pend_reg.offset};
   assign read_addr = {readRequest_bits_vs, readRequest_bits_offset};

   // Gating with reset keeps a pending write from landing in the bank on
   // the reset edge; the write is simply dropped.
   assign commit = pend_valid_reg & ~readRequest_valid & ~reset;
   assign vrfWriteRequest_ready = ~pend_valid_reg | commit;
   assign accept = vrfWriteRequest_valid & vrfWriteRequest_ready;

   // Only the pre-edge pending entry is forwarded; a write accepted in the
   // same cycle as the read is not yet visible.
   assign fwd_hit_next = readRequest_valid & pend_valid_reg & (pend_addr == read_addr);

   assign bank_addr = readRequest_valid ? read_addr : pend_addr;

   always_comb begin
      done_next = '0;
      if (commit && pend_reg.last) begin
         done_next[pend_reg.instructionIndex] = 1'b1;
      end
   end

   vrf_bank_masked #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_bank (
      .clk   (clock),
      .en    (readRequest_valid | commit),
      .we    (commit),
      .addr  (bank_addr),
      .wmask (pend_reg.mask),
      .wdata (pend_reg.data),
      .rdata (bank_rdata)
   );

   // Control and report state.
   always_ff @(posedge clock) begin
      if (reset) begin
         pend_valid_reg                    <= 1'b0;
         fwd_hit_reg                       <= 1'b0;
         readResult_valid                  <= 1'b0;
         writeCommit_valid                 <= 1'b0;
         writeCommit_bits_instructionIndex <= '0;
         instructionWriteDone              <= '0;
      end else begin
         if (accept) begin
            pend_valid_reg <= 1'b1;
         end else if (commit) begin
            pend_valid_reg <= 1'b0;
         end
         fwd_hit_reg                       <= fwd_hit_next;
         readResult_valid                  <= readRequest_valid;
         writeCommit_valid                 <= commit;
         writeCommit_bits_instructionIndex <= commit ? pend_reg.instructionIndex : '0;
         instructionWriteDone              <= done_next;
      end
   end

   // Payload registers carry no reset; their contents only matter while
   // the matching valid/hit flag is set.
   always_ff @(posedge clock) begin
      if (accept) begin
         pend_reg.vd               <= vrfWriteRequest_bits_vd;
         pend_reg.offset           <= vrfWriteRequest_bits_offset;
         pend_reg.mask             <= vrfWriteRequest_bits_mask;
         pend_reg.data             <= vrfWriteRequest_bits_data;
         pend_reg.last             <= vrfWriteRequest_bits_last;
         pend_reg.instructionIndex <= vrfWriteRequest_bits_instructionIndex;
      end
      fwd_mask_reg <= pend_reg.mask;
      fwd_data_reg <= pend_reg.data;
   end

   // Result is forced to zero whenever no read result is being presented.
   assign readResult_bits = readResult_valid
                          ? byte_merge(bank_rdata, fwd_data_reg,
                                       fwd_hit_reg ? fwd_mask_reg : '0)
                          : '0;

endmodule

// File: tb/tb_vrf_write_sink.sv
// Directed testbench for vrf_write_sink.
// Purpose : drives write beats and reads cycle by cycle and checks ready,
//           read data, forwarding, commit pulses and reset behaviour against
//           hand-computed values.
// Ports   : none (top-level bench).
module tb_vrf_write_sink;

   logic        clock = 1'b0;
   logic        reset;
   logic        wv;
   logic        ready;
   logic [4:0]  w_vd;
   logic [7:0]  w_off;
   logic [3:0]  w_mask;
   logic [31:0] w_data;
   logic        w_last;
   logic [2:0]  w_idx;
   logic        rv;
   logic [4:0]  r_vs;
   logic [7:0]  r_off;
   logic        res_valid;
   logic [31:0] res_bits;
   logic        cm_valid;
   logic [2:0]  cm_idx;
   logic [7:0]  done;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   vrf_write_sink dut (
      .clock                                (clock),
      .reset                                (reset),
      .vrfWriteRequest_valid                (wv),
      .vrfWriteRequest_ready                (ready),
      .vrfWriteRequest_bits_vd              (w_vd),
      .vrfWriteRequest_bits_offset          (w_off),
      .vrfWriteRequest_bits_mask            (w_mask),
      .vrfWriteRequest_bits_data            (w_data),
      .vrfWriteRequest_bits_last            (w_last),
      .vrfWriteRequest_bits_instructionIndex(w_idx),
      .readRequest_valid                    (rv),
      .readRequest_bits_vs                  (r_vs),
      .readRequest_bits_offset              (r_off),
      .readResult_valid                     (res_valid),
      .readResult_bits                      (res_bits),
      .writeCommit_valid                    (cm_valid),
      .writeCommit_bits_instructionIndex    (cm_idx),
      .instructionWriteDone                 (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance into the next cycle; inputs set afterwards apply to that cycle.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present one write beat for one cycle; the sink must be ready.
   task automatic do_write(input logic [4:0] vd, input logic [7:0] off, input logic [3:0] m,
                           input logic [31:0] d, input logic l, input logic [2:0] ix);
      wv = 1'b1; w_vd = vd; w_off = off; w_mask = m; w_data = d; w_last = l; w_idx = ix;
      #1;
      chk("wr_ready", 32'(ready), 32'd1);
      tick();
      wv = 1'b0;
   endtask

   task automatic do_read(input string tag, input logic [4:0] vs, input logic [7:0] off,
                          input logic [31:0] exp);
      rv = 1'b1; r_vs = vs; r_off = off;
      tick();
      rv = 1'b0;
      chk({tag, "_valid"}, 32'(res_valid), 32'd1);
      chk(tag, res_bits, exp);
   endtask

   task automatic chk_report(input string tag, input logic v, input logic [2:0] ix,
                             input logic [7:0] dn);
      chk({tag, "_cvalid"}, 32'(cm_valid), 32'(v));
      chk({tag, "_cidx"},   32'(cm_idx),   32'(ix));
      chk({tag, "_done"},   32'(done),     32'(dn));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; wv = 1'b0; rv = 1'b0;
      w_vd = '0; w_off = '0; w_mask = '0; w_data = '0; w_last = 1'b0; w_idx = '0;
      r_vs = '0; r_off = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // Reset state.
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_rvalid", 32'(res_valid), 32'd0);
      chk("rst_rbits", res_bits, 32'd0);
      chk_report("rst", 1'b0, 3'd0, 8'h00);

      // Full-mask write, last beat of instruction 5.
      do_write(5'd3, 8'h10, 4'hF, 32'hDEADBEEF, 1'b1, 3'd5);
      chk_report("w1_pend", 1'b0, 3'd0, 8'h00);
      tick();
      chk_report("w1_commit", 1'b1, 3'd5, 8'h20);
      tick();
      chk_report("w1_after", 1'b0, 3'd0, 8'h00);
      do_read("w1_read", 5'd3, 8'h10, 32'hDEADBEEF);

      // Partial mask merge with the committed word.
      do_write(5'd1, 8'h20, 4'hF, 32'h11223344, 1'b0, 3'd0);
      do_write(5'd1, 8'h20, 4'h5, 32'hAABBCCDD, 1'b0, 3'd1);
      tick();
      do_read("partial", 5'd1, 8'h20, 32'h11BB33DD);

      // Reads stall the pending write for three cycles.
      tick();
      do_write(5'd2, 8'h30, 4'hF, 32'h55667788, 1'b0, 3'd2);
      for (int c = 0; c < 3; c++) begin
         rv = 1'b1; r_vs = 5'd7; r_off = 8'h00;
         #1;
         chk("stall_ready", 32'(ready), 32'd0);
         tick();
         chk("stall_cvalid", 32'(cm_valid), 32'd0);
         chk("stall_rvalid", 32'(res_valid), 32'd1);
      end
      rv = 1'b0;
      #1;
      chk("unstall_ready", 32'(ready), 32'd1);
      tick();
      chk_report("unstall", 1'b1, 3'd2, 8'h00);
      do_read("stall_read", 5'd2, 8'h30, 32'h55667788);

      // Forwarding of the pending bytes over the stored word.
      do_write(5'd0, 8'h00, 4'hF, 32'h12345678, 1'b0, 3'd0);
      tick();
      do_write(5'd0, 8'h00, 4'h3, 32'h0000CAFE, 1'b0, 3'd1);
      rv = 1'b1; r_vs = 5'd0; r_off = 8'h00;
      #1;
      chk("fwd_ready", 32'(ready), 32'd0);
      tick();
      rv = 1'b0;
      chk("fwd_rvalid", 32'(res_valid), 32'd1);
      chk("fwd_bits", res_bits, 32'h1234CAFE);
      chk("fwd_nocommit", 32'(cm_valid), 32'd0);
      tick();
      chk_report("fwd_commit", 1'b1, 3'd1, 8'h00);
      do_read("fwd_stored", 5'd0, 8'h00, 32'h1234CAFE);

      // A write accepted in the same cycle as a read is not forwarded.
      do_write(5'd0, 8'h40, 4'hF, 32'h01020304, 1'b0, 3'd0);
      tick();
      wv = 1'b1; w_vd = 5'd0; w_off = 8'h40; w_mask = 4'hF; w_data = 32'hFFFFFFFF;
      w_last = 1'b0; w_idx = 3'd4;
      rv = 1'b1; r_vs = 5'd0; r_off = 8'h40;
      #1;
      chk("same_ready", 32'(ready), 32'd1);
      tick();
      wv = 1'b0; rv = 1'b0;
      chk("same_bits", res_bits, 32'h01020304);
      tick();
      do_read("same_after", 5'd0, 8'h40, 32'hFFFFFFFF);

      // Eight back-to-back writes; only beat 7 carries last.
      tick();
      tick();
      for (int i = 0; i < 8; i++) begin
         wv = 1'b1; w_vd = 5'd4; w_off = 8'(i); w_mask = 4'hF;
         w_data = 32'hA0000000 | 32'(i); w_last = (i == 7); w_idx = 3'(i);
         #1;
         chk("tp_ready", 32'(ready), 32'd1);
         chk("tp_cvalid", 32'(cm_valid), (i >= 2) ? 32'd1 : 32'd0);
         if (i >= 2) begin
            chk("tp_cidx", 32'(cm_idx), 32'(i - 2));
            chk("tp_done", 32'(done), 32'd0);
         end
         tick();
      end
      wv = 1'b0;
      chk_report("tp_6", 1'b1, 3'd6, 8'h00);
      tick();
      chk_report("tp_7", 1'b1, 3'd7, 8'h80);
      tick();
      chk_report("tp_end", 1'b0, 3'd0, 8'h00);
      do_read("tp_read3", 5'd4, 8'd3, 32'hA0000003);
      do_read("tp_read7", 5'd4, 8'd7, 32'hA0000007);

      // Reset drops a pending write without commit or report.
      do_write(5'd5, 8'h01, 4'hF, 32'h12121212, 1'b0, 3'd0);
      tick();
      do_write(5'd5, 8'h01, 4'hF, 32'h99999999, 1'b1, 3'd3);
      reset = 1'b1;
      tick();
      chk_report("rstp", 1'b0, 3'd0, 8'h00);
      reset = 1'b0;
      #1;
      chk("rstp_ready", 32'(ready), 32'd1);
      tick();
      chk_report("rstp_after", 1'b0, 3'd0, 8'h00);
      chk("rstp_rvalid", 32'(res_valid), 32'd0);
      do_read("rstp_read", 5'd5, 8'h01, 32'h12121212);

      // A read issued during reset produces no result.
      reset = 1'b1; rv = 1'b1; r_vs = 5'd5; r_off = 8'h01;
      tick();
      reset = 1'b0; rv = 1'b0;
      chk("rst_read_valid", 32'(res_valid), 32'd0);
      chk("rst_read_bits", res_bits, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
